boot_sequencer: RTL and testbench

BOOT_SEQUENCER -- requirements
Module: boot_sequencer

---
 rtl/boot_pkg.sv | 16 +
 rtl/host_presence_timer.sv | 40 ++++
 rtl/boot_sequencer.sv | 93 +++++++++
 tb/tb_boot_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and widths for the warm-boot sequencer.
package boot_pkg;

    localparam int unsigned IMAGE_W = 2;
    localparam int unsigned TIMER_W = 32;

    typedef logic [IMAGE_W-1:0] image_t;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        PEND   = 2'd1,
        SETTLE = 2'd2,
        BOOT   = 2'd3
    } boot_state_t;

endpackage

// File: rtl/host_presence_timer.sv
// Tracks USB host activity: a saturating counter of cycles since the last SOF.
module host_presence_timer
    import boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 48000000
) (
    input  logic clk,
    input  logic reset,
    input  logic sof_valid,
    output logic timeout,
    output logic host_present
);

    localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES);

    logic [TIMER_W-1:0] timer;

    // An SOF in the same cycle as the limit cancels that timeout.
    assign timeout = (timer == LIMIT) && !sof_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            timer        <= '0;
            host_present <= 1'b0;
        end else begin
            if (sof_valid) begin
                timer <= '0;
            end else if (timer < LIMIT) begin
                timer <= timer + TIMER_W'(1);
            end

            if (sof_valid) begin
                host_present <= 1'b1;
            end else if (timeout) begin
                host_present <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/boot_sequencer.sv
// Decides when and which image to warm-boot, then drives SB_WARMBOOT with
// the image select held stable for SETTLE_CYCLES before BOOT rises.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 48000000,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter image_t      DEFAULT_IMAGE  = 2'b01
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sof_valid,
    input  logic               boot_req,
    input  logic [IMAGE_W-1:0] boot_image,
    input  logic               boot_inhibit,
    output logic [IMAGE_W-1:0] warmboot_s,
    output logic               warmboot_boot,
    output logic               host_present,
    output logic               boot_pending
);

    localparam int unsigned SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

    boot_state_t         state;
    image_t              target;
    logic [SETTLE_W-1:0] settle_cnt;
    logic                timeout;
    image_t              decision_image_c;

    host_presence_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_presence (
        .clk         (clk),
        .reset       (reset),
        .sof_valid   (sof_valid),
        .timeout     (timeout),
        .host_present(host_present)
    );

    // An explicit request beats a coincident host-absence timeout.
    assign decision_image_c = boot_req ? boot_image : DEFAULT_IMAGE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= WAIT;
            target        <= '0;
            settle_cnt    <= '0;
            warmboot_s    <= '0;
            warmboot_boot <= 1'b0;
            boot_pending  <= 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    if (boot_req || timeout) begin
                        target       <= decision_image_c;
                        boot_pending <= 1'b1;
                        if (boot_inhibit) begin
                            state <= PEND;
                        end else begin
                            state      <= SETTLE;
                            warmboot_s <= decision_image_c;
                            settle_cnt <= '0;
                        end
                    end
                end
                PEND: begin
                    if (!boot_inhibit) begin
                        state      <= SETTLE;
                        warmboot_s <= target;
                        settle_cnt <= '0;
                    end
                end
                SETTLE: begin
                    // Image select has been stable for the full settle window.
                    if (settle_cnt == SETTLE_LAST) begin
                        state         <= BOOT;
                        warmboot_boot <= 1'b1;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_W'(1);
                    end
                end
                BOOT: begin
                    state <= BOOT;
                end
                default: begin
                    state <= WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_sequencer.sv
// Scoreboard bench for boot_sequencer: a per-cycle behavioural model feeds
// expected outputs into a queue that an independent monitor drains.
module tb_boot_sequencer;

    localparam int unsigned T   = 100;
    localparam int unsigned S   = 4;
    localparam logic [1:0]  DEF = 2'b01;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof_valid = 1'b0;
    logic       boot_req = 1'b0;
    logic [1:0] boot_image = 2'b00;
    logic       boot_inhibit = 1'b0;
    logic [1:0] warmboot_s;
    logic       warmboot_boot;
    logic       host_present;
    logic       boot_pending;

    always #5 clk = ~clk;

    boot_sequencer #(
        .TIMEOUT_CYCLES(T),
        .SETTLE_CYCLES (S),
        .DEFAULT_IMAGE (DEF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sof_valid    (sof_valid),
        .boot_req     (boot_req),
        .boot_image   (boot_image),
        .boot_inhibit (boot_inhibit),
        .warmboot_s   (warmboot_s),
        .warmboot_boot(warmboot_boot),
        .host_present (host_present),
        .boot_pending (boot_pending)
    );

    typedef struct packed {
        logic [1:0] ws;
        logic       wb;
        logic       hp;
        logic       bp;
    } obs_t;

    obs_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Model: cycles since last SOF, whether a boot was decided, and the
    // edge at which the image select was committed to the pins.
    int         m_quiet = 0;
    bit         m_host = 0;
    bit         m_decided = 0;
    bit         m_deferred = 0;
    bit         m_committed = 0;
    logic [1:0] m_tgt = 2'b00;
    int         m_edge = 0;
    int         m_commit_edge = 0;

    task automatic step(input bit rst, input bit sof, input bit req,
                        input logic [1:0] img, input bit inh);
        bit   tmo;
        obs_t e;
        @(negedge clk);
        reset        = rst;
        sof_valid    = sof;
        boot_req     = req;
        boot_image   = img;
        boot_inhibit = inh;
        m_edge++;
        if (rst) begin
            m_quiet     = 0;
            m_host      = 0;
            m_decided   = 0;
            m_deferred  = 0;
            m_committed = 0;
            m_tgt       = 2'b00;
        end else begin
            tmo = (m_quiet == int'(T)) && !sof;
            if (!m_decided) begin
                if (req || tmo) begin
                    m_decided = 1;
                    m_tgt     = req ? img : DEF;
                    if (inh) begin
                        m_deferred = 1;
                    end else begin
                        m_committed   = 1;
                        m_commit_edge = m_edge;
                    end
                end
            end else if (m_deferred && !inh) begin
                m_deferred    = 0;
                m_committed   = 1;
                m_commit_edge = m_edge;
            end
            if (sof) m_host = 1;
            else if (tmo) m_host = 0;
            m_quiet = sof ? 0 : ((m_quiet < int'(T)) ? m_quiet + 1 : int'(T));
        end
        e.ws = m_committed ? m_tgt : 2'b00;
        e.wb = m_committed && (m_edge >= m_commit_edge + int'(S));
        e.hp = m_host;
        e.bp = m_decided;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, 0);
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %b expected %b (ws,wb,hp,bp)", name, act, req);
    endtask

    function automatic logic [4:0] outs();
        return {warmboot_s, warmboot_boot, host_present, boot_pending};
    endfunction

    // Monitor: compares every registered output sample against the model.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {warmboot_s, warmboot_boot, host_present, boot_pending};
                n_checks++;
                if (a === e) n_pass++;
                else $display("FAIL scoreboard t=%0t: got ws=%b wb=%b hp=%b bp=%b expected ws=%b wb=%b hp=%b bp=%b",
                              $time, a.ws, a.wb, a.hp, a.bp, e.ws, e.wb, e.hp, e.bp);
            end
        end
    end

    initial begin
        bit         r, s, q, inh;
        logic [1:0] im;
        int         guard;

        step(1, 0, 0, 2'b00, 0);
        step(1, 0, 0, 2'b00, 0);
        #2 chk("reset_state", outs(), 5'b00000);

        // Regular SOF keeps the host present and never boots.
        for (int i = 0; i < 1000; i++) step(0, (i % 50) == 0, 0, 2'b00, 0);
        #2 chk("sof_keepalive", outs(), 5'b00010);

        // Host absence: default image one cycle after timeout, BOOT 4 later.
        step(1, 0, 0, 2'b00, 0);
        idle(100);
        #2 chk("pre_timeout", outs(), 5'b00000);
        idle(1);
        #2 chk("timeout_image", outs(), 5'b01001);
        idle(3);
        #2 chk("settle_hold", outs(), 5'b01001);
        idle(1);
        #2 chk("timeout_boot", outs(), 5'b01101);
        idle(20);
        #2 chk("boot_terminal", outs(), 5'b01101);

        // Inhibited request is deferred; a second request in PEND is ignored.
        step(1, 0, 0, 2'b00, 0);
        step(0, 0, 1, 2'b10, 1);
        for (int i = 0; i < 19; i++) step(0, 0, i == 5, 2'b11, 1);
        #2 chk("pend_hold", outs(), 5'b00001);
        step(0, 0, 0, 2'b00, 0);
        #2 chk("pend_release", outs(), 5'b10001);
        idle(3);
        #2 chk("pend_settle", outs(), 5'b10001);
        idle(1);
        #2 chk("pend_boot", outs(), 5'b10101);

        // Request coinciding with timeout wins.
        step(1, 0, 0, 2'b00, 0);
        guard = 0;
        while (m_quiet != int'(T) && guard < 300) begin idle(1); guard++; end
        step(0, 0, 1, 2'b11, 0);
        #2 chk("req_beats_timeout", outs(), 5'b11001);

        // Reset during SETTLE abandons the boot; fresh timeout needed.
        step(1, 0, 0, 2'b00, 0);
        guard = 0;
        while (!m_committed && guard < 300) begin idle(1); guard++; end
        idle(1);
        step(1, 0, 0, 2'b00, 0);
        #2 chk("reset_in_settle", outs(), 5'b00000);
        idle(100);
        #2 chk("fresh_timeout_wait", outs(), 5'b00000);
        idle(1);
        #2 chk("fresh_timeout", outs(), 5'b01001);

        // SOF at the timeout limit cancels it and restarts the count.
        step(1, 0, 0, 2'b00, 0);
        guard = 0;
        while (m_quiet != int'(T) && guard < 300) begin idle(1); guard++; end
        step(0, 1, 0, 2'b00, 0);
        #2 chk("sof_cancels_timeout", outs(), 5'b00010);
        idle(100);
        #2 chk("restart_count", outs(), 5'b00010);
        idle(1);
        #2 chk("restart_timeout", outs(), 5'b01001);

        // Randomised traffic against the model.
        inh = 0;
        step(1, 0, 0, 2'b00, 0);
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 399) == 0) ||
                 (m_committed && m_edge > m_commit_edge + int'(S) + 10);
            s  = ($urandom_range(0, 79) == 0);
            q  = ($urandom_range(0, 149) == 0);
            im = 2'($urandom);
            if ($urandom_range(0, 15) == 0) inh = !inh;
            step(r, s, q, im, inh);
        end

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
